// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface instr_fetch_if #(
    parameter int IW = 16,
    parameter int AW = 8
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack bus into a
// single-entry instruction register, handles redirects and request timeouts.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_FETCH | normal operation; issue requests whenever the IR can be refilled
//  S_DRAIN | redirect arrived with a request in flight; wait for its ack,
//          | throw the data away, then restart at the saved redirect target
//  S_HALT  | a request went unanswered for TIMEOUT cycles; idle until reset
module instr_fetch #(
    parameter int            IW       = 16,
    parameter int            AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            TIMEOUT  = 15
) (
    input  logic                 clock,
    input  logic                 reset_n,
    instr_fetch_if.master        imem,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [AW-1:0]        redirect_pc,
    output logic                 instr_valid,
    output logic [IW-1:0]        instr,
    output logic [3:0]           opCode,
    output logic [AW-1:0]        pc_out,
    output logic [AW-1:0]        pc_plus1,
    output logic                 fetch_err
);

    typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_HALT} state_t;

    localparam logic [7:0]    TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [AW-1:0] PC_ONE      = {{(AW-1){1'b0}}, 1'b1};

    state_t        state, state_n;
    logic [AW-1:0] pc, pc_n;
    logic [AW-1:0] saved_pc, saved_pc_n;
    logic [AW-1:0] pc_out_n;
    logic [IW-1:0] instr_n;
    logic          instr_valid_n;
    logic          fetch_err_n;
    logic [7:0]    wait_cnt, wait_cnt_n;
    logic          armed;

    logic          req;
    logic          ack;
    logic          timeout_hit;

    // Request: held through DRAIN; in FETCH asserted whenever the IR is empty
    // or being consumed right now, so a zero-wait memory sustains 1 instr/cycle.
    // 'armed' keeps the bus quiet in the first clock after reset release.
    always_comb begin
        req = 1'b0;
        if (armed) begin
            if (state == S_DRAIN)
                req = 1'b1;
            else if (state == S_FETCH)
                req = !instr_valid || !stall;
        end
    end

    assign ack         = req && imem.imem_ack;
    assign timeout_hit = req && !imem.imem_ack && (wait_cnt + 8'd1 == TIMEOUT_CNT);

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;
    assign opCode         = instr[IW-1:IW-4];
    assign pc_plus1       = pc_out + PC_ONE;

    // Next-state and datapath updates; redirect outranks ack and delivery,
    // timeout outranks everything.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        saved_pc_n    = saved_pc;
        pc_out_n      = pc_out;
        instr_n       = instr;
        instr_valid_n = instr_valid;
        fetch_err_n   = fetch_err;
        wait_cnt_n    = wait_cnt;

        case (state)
            S_FETCH: begin
                if (req)
                    wait_cnt_n = ack ? 8'd0 : wait_cnt + 8'd1;
                if (timeout_hit) begin
                    state_n       = S_HALT;
                    fetch_err_n   = 1'b1;
                    instr_valid_n = 1'b0;
                end else if (redirect_valid) begin
                    instr_valid_n = 1'b0;
                    if (req && !ack) begin
                        state_n    = S_DRAIN;
                        saved_pc_n = redirect_pc;
                    end else begin
                        pc_n = redirect_pc;
                    end
                end else if (ack) begin
                    instr_n       = imem.imem_rdata;
                    pc_out_n      = pc;
                    instr_valid_n = 1'b1;
                    pc_n          = pc + PC_ONE;
                end else if (instr_valid && !stall) begin
                    instr_valid_n = 1'b0;
                end
            end
            S_DRAIN: begin
                if (timeout_hit) begin
                    state_n       = S_HALT;
                    fetch_err_n   = 1'b1;
                    instr_valid_n = 1'b0;
                end else begin
                    if (redirect_valid)
                        saved_pc_n = redirect_pc;
                    if (ack) begin
                        pc_n       = redirect_valid ? redirect_pc : saved_pc;
                        state_n    = S_FETCH;
                        wait_cnt_n = 8'd0;
                    end else begin
                        wait_cnt_n = wait_cnt + 8'd1;
                    end
                end
            end
            S_HALT: begin
                instr_valid_n = 1'b0;
            end
            default: begin
                state_n = S_HALT;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            saved_pc    <= '0;
            pc_out      <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= 8'd0;
            armed       <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            saved_pc    <= saved_pc_n;
            pc_out      <= pc_out_n;
            instr       <= instr_n;
            instr_valid <= instr_valid_n;
            fetch_err   <= fetch_err_n;
            wait_cnt    <= wait_cnt_n;
            armed       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory returns {~addr[3:0], 4'hA, addr}.
module tb_instr_fetch;

    logic       clock;
    logic       reset_n;
    logic       stall;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic       instr_valid;
    logic [15:0] instr;
    logic [3:0] opCode;
    logic [7:0] pc_out;
    logic [7:0] pc_plus1;
    logic       fetch_err;

    logic       ack_auto;
    logic       ack_man;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_if #(.IW(16), .AW(8)) bus ();

    assign bus.imem_ack   = ack_auto ? bus.imem_req : ack_man;
    assign bus.imem_rdata = {~bus.imem_addr[3:0], 4'hA, bus.imem_addr};

    instr_fetch #(
        .IW(16), .AW(8), .RESET_PC(8'h10), .TIMEOUT(4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem           (bus.master),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .opCode         (opCode),
        .pc_out         (pc_out),
        .pc_plus1       (pc_plus1),
        .fetch_err      (fetch_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        ack_auto       = 1'b1;
        ack_man        = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_err",   32'(fetch_err),   32'h0);
        check("rst_pcout", 32'(pc_out),      32'h0);
        check("rst_instr", 32'(instr),       32'h0);

        // 1: reset release, zero-wait memory
        reset_n = 1'b1;
        #1;
        check("t1_req_c0", 32'(bus.imem_req), 32'h0);
        tick();
        check("t1_req_c1",   32'(bus.imem_req),  32'h1);
        check("t1_addr_c1",  32'(bus.imem_addr), 32'h10);
        check("t1_valid_c1", 32'(instr_valid),   32'h0);
        tick();
        check("t1_valid_c2", 32'(instr_valid),   32'h1);
        check("t1_instr_c2", 32'(instr),         32'hFA10);
        check("t1_op_c2",    32'(opCode),        32'hF);
        check("t1_pcout_c2", 32'(pc_out),        32'h10);
        check("t1_addr_c2",  32'(bus.imem_addr), 32'h11);
        check("t1_req_c2",   32'(bus.imem_req),  32'h1);
        tick();
        check("t1_instr_c3", 32'(instr),         32'hEA11);
        check("t1_op_c3",    32'(opCode),        32'hE);
        check("t1_addr_c3",  32'(bus.imem_addr), 32'h12);

        // 2: stall for 3 cycles holds IR and blocks requests
        stall = 1'b1;
        #1;
        check("t2_req_s1", 32'(bus.imem_req), 32'h0);
        tick();
        check("t2_req_s2",   32'(bus.imem_req), 32'h0);
        check("t2_instr_s2", 32'(instr),        32'hEA11);
        tick();
        check("t2_req_s3",   32'(bus.imem_req), 32'h0);
        check("t2_pcout_s3", 32'(pc_out),       32'h11);
        check("t2_valid_s3", 32'(instr_valid),  32'h1);
        tick();
        stall = 1'b0;
        #1;
        check("t2_req_go",  32'(bus.imem_req),  32'h1);
        check("t2_addr_go", 32'(bus.imem_addr), 32'h12);
        tick();
        check("t2_instr", 32'(instr), 32'hDA12);

        // 3: ack delayed by 3 cycles
        ack_auto = 1'b0;
        ack_man  = 1'b0;
        #1;
        check("t3_addr_r1", 32'(bus.imem_addr), 32'h13);
        tick();
        check("t3_addr_r2",  32'(bus.imem_addr), 32'h13);
        check("t3_valid_r2", 32'(instr_valid),   32'h0);
        tick();
        check("t3_addr_r3", 32'(bus.imem_addr), 32'h13);
        check("t3_req_r3",  32'(bus.imem_req),  32'h1);
        tick();
        ack_man = 1'b1;
        #1;
        check("t3_addr_r4", 32'(bus.imem_addr), 32'h13);
        tick();
        ack_man = 1'b0;
        stall   = 1'b1;
        #1;
        check("t3_instr", 32'(instr),         32'hCA13);
        check("t3_pcout", 32'(pc_out),        32'h13);
        check("t3_next",  32'(bus.imem_addr), 32'h14);
        check("t3_err",   32'(fetch_err),     32'h0);

        // 4: redirect to 0x40 while request to 0x05 is outstanding
        redirect_valid = 1'b1;
        redirect_pc    = 8'h05;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        #1;
        check("t4_addr05",  32'(bus.imem_addr), 32'h05);
        check("t4_valid05", 32'(instr_valid),   32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t4_drain_req",  32'(bus.imem_req),  32'h1);
        check("t4_drain_addr", 32'(bus.imem_addr), 32'h05);
        tick();
        ack_man = 1'b1;
        #1;
        check("t4_ack_addr",  32'(bus.imem_addr), 32'h05);
        check("t4_ack_valid", 32'(instr_valid),   32'h0);
        tick();
        ack_man = 1'b0;
        #1;
        check("t4_disc_valid", 32'(instr_valid),   32'h0);
        check("t4_new_req",    32'(bus.imem_req),  32'h1);
        check("t4_new_addr",   32'(bus.imem_addr), 32'h40);
        ack_auto = 1'b1;
        tick();
        check("t4_instr", 32'(instr),  32'hFA40);
        check("t4_pcout", 32'(pc_out), 32'h40);

        // 5: PC wrap at 0xFF
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFF;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        #1;
        check("t5_addrFF", 32'(bus.imem_addr), 32'hFF);
        tick();
        check("t5_pcout",  32'(pc_out),        32'hFF);
        check("t5_plus1",  32'(pc_plus1),      32'h00);
        check("t5_instr",  32'(instr),         32'h0AFF);
        check("t5_wrap",   32'(bus.imem_addr), 32'h00);
        tick();
        check("t5_pcout0", 32'(pc_out),        32'h00);
        check("t5_plus1b", 32'(pc_plus1),      32'h01);
        check("t5_instr0", 32'(instr),         32'hFA00);

        // 6: no ack at all -> timeout after 4 un-acked cycles
        ack_auto = 1'b0;
        ack_man  = 1'b0;
        #1;
        check("t6_req1", 32'(bus.imem_req), 32'h1);
        tick();
        tick();
        check("t6_err3", 32'(fetch_err), 32'h0);
        tick();
        check("t6_err4", 32'(fetch_err), 32'h0);
        tick();
        check("t6_err",   32'(fetch_err),    32'h1);
        check("t6_req",   32'(bus.imem_req), 32'h0);
        check("t6_valid", 32'(instr_valid),  32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h20;
        ack_man        = 1'b1;
        tick();
        redirect_valid = 1'b0;
        ack_man        = 1'b0;
        tick();
        check("t6_halt_err",   32'(fetch_err),    32'h1);
        check("t6_halt_req",   32'(bus.imem_req), 32'h0);
        check("t6_halt_valid", 32'(instr_valid),  32'h0);
        reset_n = 1'b0;
        #1;
        check("t6_rst_err", 32'(fetch_err), 32'h0);
        tick();
        reset_n = 1'b1;
        ack_auto = 1'b1;
        tick();
        check("t6_restart_addr", 32'(bus.imem_addr), 32'h10);
        check("t6_restart_req",  32'(bus.imem_req),  32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
